sram_arbiter: RTL

//  Shares the single external-SRAM byte controller between two requesters: the VGA pixel fetch
//  (read-only, high priority) and a host/frame-writer port (read or write, low priority).

---
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Arbitrates one SRAM byte controller between a high-priority video read port and a host read/write port.
// Optional host anti-starvation guard is enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter #(
  parameter int MEM_LAT    = 3,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_req_in,
  input  logic [18:0] vid_addr_in,
  output logic        vid_ack_out,
  output logic [7:0]  vid_rdata_out,
  output logic        vid_valid_out,
  input  logic        host_req_in,
  input  logic        host_rw_in,
  input  logic [18:0] host_addr_in,
  input  logic [7:0]  host_wdata_in,
  output logic        host_ack_out,
  output logic [7:0]  host_rdata_out,
  output logic        host_done_out,
  output logic        mem_trig_out,
  output logic        mem_rw_out,
  output logic [18:0] mem_addr_out,
  output logic [7:0]  mem_wdata_out,
  input  logic [7:0]  mem_r_data_in
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int             LAT_W   = $clog2(MEM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_CAP = LAT_W'(MEM_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LAT);

  if (MEM_LAT < 2) begin : g_lat_check
    $error("sram_arbiter: MEM_LAT must be at least 2");
  end
  if (STARVE_MAX < 1) begin : g_starve_check
    $error("sram_arbiter: STARVE_MAX must be at least 1");
  end

  logic [1:0]       r_state;
  logic             r_owner_host;
  logic [LAT_W-1:0] r_lat;
  logic             r_mem_trig;
  logic             r_mem_rw;
  logic [18:0]      r_mem_addr;
  logic [7:0]       r_mem_wdata;
  logic             r_vid_ack;
  logic             r_vid_valid;
  logic [7:0]       r_vid_rdata;
  logic             r_host_ack;
  logic             r_host_done;
  logic [7:0]       r_host_rdata;

  logic w_idle;
  logic w_host_turn;
  logic w_grant_vid;
  logic w_grant_host;

  assign w_idle = (r_state == IDLE);

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int STV_W = ($clog2(STARVE_MAX + 1) < 4) ? 4 : $clog2(STARVE_MAX + 1);

  logic [STV_W-1:0] r_starve;

  // Counts video grants that jumped a waiting host; saturates at STARVE_MAX because the host then wins.
  assign w_host_turn = (r_starve == STV_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (w_idle) begin
      if (!host_req_in || w_grant_host) begin
        r_starve <= '0;
      end else if (w_grant_vid) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end
`else
  assign w_host_turn = 1'b0;
`endif

  assign w_grant_vid  = w_idle && vid_req_in && !(host_req_in && w_host_turn);
  assign w_grant_host = w_idle && host_req_in && (!vid_req_in || w_host_turn);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_owner_host <= 1'b0;
      r_lat        <= '0;
      r_mem_trig   <= 1'b0;
      r_mem_rw     <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_vid_ack    <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_vid_rdata  <= '0;
      r_host_ack   <= 1'b0;
      r_host_done  <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_mem_trig  <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_host_ack  <= 1'b0;
      r_vid_valid <= 1'b0;
      r_host_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_grant_vid || w_grant_host) begin
            r_owner_host <= w_grant_host;
            r_mem_rw     <= w_grant_host ? host_rw_in : 1'b1;
            r_mem_addr   <= w_grant_host ? host_addr_in : vid_addr_in;
            if (w_grant_host) begin
              r_mem_wdata <= host_wdata_in;
            end
            r_mem_trig <= 1'b1;
            r_vid_ack  <= w_grant_vid;
            r_host_ack <= w_grant_host;
            r_state    <= ISSUE;
          end
        end

        ISSUE: begin
          r_lat   <= LAT_W'(1);
          r_state <= WAIT;
        end

        // Result is registered one cycle before the final WAIT cycle so the pulse lands MEM_LAT after trig.
        WAIT: begin
          if (r_lat == LAT_CAP) begin
            if (r_owner_host) begin
              r_host_done <= 1'b1;
              if (r_mem_rw) begin
                r_host_rdata <= mem_r_data_in;
              end
            end else begin
              r_vid_valid <= 1'b1;
              r_vid_rdata <= mem_r_data_in;
            end
            r_lat <= r_lat + 1'b1;
          end else if (r_lat == LAT_END) begin
            r_lat   <= '0;
            r_state <= IDLE;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vid_ack_out    = r_vid_ack;
  assign vid_valid_out  = r_vid_valid;
  assign vid_rdata_out  = r_vid_rdata;
  assign host_ack_out   = r_host_ack;
  assign host_done_out  = r_host_done;
  assign host_rdata_out = r_host_rdata;
  assign mem_trig_out   = r_mem_trig;
  assign mem_rw_out     = r_mem_rw;
  assign mem_addr_out   = r_mem_addr;
  assign mem_wdata_out  = r_mem_wdata;

endmodule
